multicycle_control_unit: RTL and testbench

- Parametrised multi-cycle sequencer. It replaces the purely combinational opcode decoder.
- It owns the instruction register, the immediate register, and a fetch/decode/execute/memory state machine.
- Memory accesses wait on a ready handshake. Two-byte instructions are fetched as two sequential bytes.
- Sits between program/data memory and the datapath (register file, ALU, PC) in cpu_top.

---
 rtl/multicycle_control_unit.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the small CPU.
// Owns the instruction and immediate registers and the retired-instruction counter.
module multicycle_control_unit #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 2,
    parameter int ALU_OP_W   = 4,
    parameter bit EXT_ALU    = 1'b0,
    parameter int COUNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  instr_fetch,
    output logic                  pc_inc,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     imm,
    output logic [REG_ADDR_W-1:0] reg_dst,
    output logic [REG_ADDR_W-1:0] reg_src,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  reg_write,
    output logic                  wb_sel,
    output logic                  illegal,
    output logic                  halted,
    output logic [COUNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_LOAD  = 4'b1001;
    localparam logic [3:0] OP_STORE = 4'b1101;
    localparam logic [3:0] OP_HLT   = 4'b1111;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   ir_q;
    logic [DATA_W-1:0]   imm_q;
    logic [COUNT_W-1:0]  retired_q;

    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] field_a;
    logic [REG_ADDR_W-1:0] field_b;
    logic                  alu_legal;
    logic [ALU_OP_W-1:0]   alu_code;
    logic                  retire_en;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign field_a = ir_q[2*REG_ADDR_W-1 : REG_ADDR_W];
    assign field_b = ir_q[REG_ADDR_W-1 : 0];

    // Base ALU ops are always legal; the logic ops only when the extended ALU is built in.
    always_comb begin
        alu_legal = 1'b0;
        alu_code  = '0;
        unique case (opcode)
            OP_ADD: begin alu_legal = 1'b1;    alu_code = ALU_OP_W'(0); end
            OP_SUB: begin alu_legal = 1'b1;    alu_code = ALU_OP_W'(1); end
            OP_AND: begin alu_legal = EXT_ALU; alu_code = ALU_OP_W'(2); end
            OP_OR:  begin alu_legal = EXT_ALU; alu_code = ALU_OP_W'(3); end
            OP_XOR: begin alu_legal = EXT_ALU; alu_code = ALU_OP_W'(4); end
            default: ;
        endcase
    end

    // State register plus the datapath registers it owns.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            imm_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && mem_ready)
                ir_q <= mem_rdata;
            if (state_q == S_FETCH_IMM && mem_ready)
                imm_q <= mem_rdata;
            if (retire_en && retired_q != '1)
                retired_q <= retired_q + COUNT_W'(1);
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_NOP)                            state_d = S_FETCH;
                else if (opcode == OP_HLT)                       state_d = S_HALT;
                else if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_FETCH_IMM;
                else if (alu_legal)                              state_d = S_EXEC;
                else                                             state_d = S_FETCH;
            end
            S_FETCH_IMM: if (mem_ready) state_d = S_MEM;
            S_EXEC:      state_d = S_FETCH;
            S_MEM:       if (mem_ready) state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state and IR; mem_ready only qualifies completion strobes.
    always_comb begin
        instr_fetch = 1'b0;
        pc_inc      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_dst     = field_a;
        reg_src     = field_b;
        alu_op      = '0;
        reg_write   = 1'b0;
        wb_sel      = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        retire_en   = 1'b0;
        unique case (state_q)
            S_FETCH, S_FETCH_IMM: begin
                instr_fetch = 1'b1;
                pc_inc      = mem_ready;
            end
            S_DECODE: begin
                if (opcode == OP_NOP || opcode == OP_HLT)
                    retire_en = 1'b1;
                else if (opcode != OP_LOAD && opcode != OP_STORE && !alu_legal)
                    illegal = 1'b1;
            end
            S_EXEC: begin
                reg_write = 1'b1;
                alu_op    = alu_code;
                retire_en = 1'b1;
            end
            S_MEM: begin
                retire_en = mem_ready;
                if (opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    reg_src   = field_a;
                end else begin
                    mem_read  = 1'b1;
                    reg_write = mem_ready;
                    wb_sel    = mem_ready;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign imm     = imm_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench: two instances (base ALU with 16-bit counter, extended ALU
// with 2-bit counter) share stimulus; each table row names which instance it checks.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] mem_rdata;
    logic       mem_ready;

    logic       a_fetch, a_pc, a_mrd, a_mwr, a_rw, a_wb, a_ill, a_hlt;
    logic [1:0] a_dst, a_src;
    logic [3:0] a_alu;
    logic [7:0] a_imm;
    logic [15:0] a_ret;

    logic       b_fetch, b_pc, b_mrd, b_mwr, b_rw, b_wb, b_ill, b_hlt;
    logic [1:0] b_dst, b_src;
    logic [3:0] b_alu;
    logic [7:0] b_imm;
    logic [1:0] b_ret;

    always #5 clk = ~clk;

    multicycle_control_unit #(.EXT_ALU(1'b0), .COUNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .instr_fetch(a_fetch), .pc_inc(a_pc), .mem_read(a_mrd), .mem_write(a_mwr),
        .imm(a_imm), .reg_dst(a_dst), .reg_src(a_src), .alu_op(a_alu),
        .reg_write(a_rw), .wb_sel(a_wb), .illegal(a_ill), .halted(a_hlt), .retired(a_ret)
    );

    multicycle_control_unit #(.EXT_ALU(1'b1), .COUNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .instr_fetch(b_fetch), .pc_inc(b_pc), .mem_read(b_mrd), .mem_write(b_mwr),
        .imm(b_imm), .reg_dst(b_dst), .reg_src(b_src), .alu_op(b_alu),
        .reg_write(b_rw), .wb_sel(b_wb), .illegal(b_ill), .halted(b_hlt), .retired(b_ret)
    );

    // Flag byte order: {instr_fetch, pc_inc, mem_read, mem_write, reg_write, wb_sel, illegal, halted}
    localparam logic [7:0] Z   = 8'h00;
    localparam logic [7:0] FT  = 8'h80;
    localparam logic [7:0] FP  = 8'hC0;
    localparam logic [7:0] MR  = 8'h20;
    localparam logic [7:0] MRW = 8'h2C;
    localparam logic [7:0] MW  = 8'h10;
    localparam logic [7:0] RW  = 8'h08;
    localparam logic [7:0] IL  = 8'h02;
    localparam logic [7:0] HL  = 8'h01;

    typedef struct {
        string       name;
        bit          rst;
        bit          sel_b;
        bit          rdy;
        logic [7:0]  rdata;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got flags=%b dst=%0d src=%0d alu=%0d imm=%h ret=%0d, want flags=%b dst=%0d src=%0d alu=%0d imm=%h ret=%0d",
                     name, act[39:32], act[31:30], act[29:28], act[27:24], act[23:16], act[15:0],
                     exp[39:32], exp[31:30], exp[29:28], exp[27:24], exp[23:16], exp[15:0]);
        end
    endtask

    task automatic add(input string nm, input bit rst, input bit sel_b, input bit rdy,
                       input logic [7:0] rd, input logic [7:0] fl, input logic [1:0] dst,
                       input logic [1:0] src, input logic [3:0] alu, input logic [7:0] im,
                       input logic [15:0] ret);
        vec_t v;
        v.name  = nm;
        v.rst   = rst;
        v.sel_b = sel_b;
        v.rdy   = rdy;
        v.rdata = rd;
        v.exp   = {fl, dst, src, alu, im, ret};
        vecs.push_back(v);
    endtask

    function automatic logic [39:0] obs_a();
        return {a_fetch, a_pc, a_mrd, a_mwr, a_rw, a_wb, a_ill, a_hlt,
                a_dst, a_src, a_alu, a_imm, a_ret};
    endfunction

    function automatic logic [39:0] obs_b();
        return {b_fetch, b_pc, b_mrd, b_mwr, b_rw, b_wb, b_ill, b_hlt,
                b_dst, b_src, b_alu, b_imm, 14'd0, b_ret};
    endfunction

    initial begin
        int cycles;
        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;

        // ADD r1,r2 with mem_ready held high
        add("add_rst",    1, 0, 1, 8'h16, Z,  0, 0, 0, 8'h00, 0);
        add("add_idle",   0, 0, 1, 8'h16, Z,  0, 0, 0, 8'h00, 0);
        add("add_fetch",  0, 0, 1, 8'h16, FP, 0, 0, 0, 8'h00, 0);
        add("add_decode", 0, 0, 1, 8'h16, Z,  1, 2, 0, 8'h00, 0);
        add("add_exec",   0, 0, 1, 8'h16, RW, 1, 2, 0, 8'h00, 0);
        add("add_next",   0, 0, 1, 8'h16, FP, 1, 2, 0, 8'h00, 1);

        // LOAD r2,[0x40] with every access taking three cycles
        add("ld_rst",     1, 0, 0, 8'h00, Z,  0, 0, 0, 8'h00, 0);
        add("ld_idle",    0, 0, 0, 8'h00, Z,  0, 0, 0, 8'h00, 0);
        add("ld_f1",      0, 0, 0, 8'h00, FT, 0, 0, 0, 8'h00, 0);
        add("ld_f2",      0, 0, 0, 8'h00, FT, 0, 0, 0, 8'h00, 0);
        add("ld_f3",      0, 0, 1, 8'h98, FP, 0, 0, 0, 8'h00, 0);
        add("ld_decode",  0, 0, 0, 8'h00, Z,  2, 0, 0, 8'h00, 0);
        add("ld_i1",      0, 0, 0, 8'h00, FT, 2, 0, 0, 8'h00, 0);
        add("ld_i2",      0, 0, 0, 8'h00, FT, 2, 0, 0, 8'h00, 0);
        add("ld_i3",      0, 0, 1, 8'h40, FP, 2, 0, 0, 8'h00, 0);
        add("ld_m1",      0, 0, 0, 8'h55, MR, 2, 0, 0, 8'h40, 0);
        add("ld_m2",      0, 0, 0, 8'h55, MR, 2, 0, 0, 8'h40, 0);
        add("ld_m3",      0, 0, 1, 8'h55, MRW,2, 0, 0, 8'h40, 0);
        add("ld_next",    0, 0, 0, 8'h00, FT, 2, 0, 0, 8'h40, 1);

        // STORE r3,[0x7F]
        add("st_rst",     1, 0, 1, 8'hDC, Z,  0, 0, 0, 8'h00, 0);
        add("st_idle",    0, 0, 1, 8'hDC, Z,  0, 0, 0, 8'h00, 0);
        add("st_fetch",   0, 0, 1, 8'hDC, FP, 0, 0, 0, 8'h00, 0);
        add("st_decode",  0, 0, 1, 8'hDC, Z,  3, 0, 0, 8'h00, 0);
        add("st_imm",     0, 0, 1, 8'h7F, FP, 3, 0, 0, 8'h00, 0);
        add("st_mem",     0, 0, 1, 8'h00, MW, 3, 3, 0, 8'h7F, 0);
        add("st_next",    0, 0, 1, 8'h00, FP, 3, 0, 0, 8'h7F, 1);

        // AND r1,r2 on the base ALU: illegal
        add("and0_rst",   1, 0, 1, 8'h36, Z,  0, 0, 0, 8'h00, 0);
        add("and0_idle",  0, 0, 1, 8'h36, Z,  0, 0, 0, 8'h00, 0);
        add("and0_fetch", 0, 0, 1, 8'h36, FP, 0, 0, 0, 8'h00, 0);
        add("and0_dec",   0, 0, 0, 8'h00, IL, 1, 2, 0, 8'h00, 0);
        add("and0_next",  0, 0, 0, 8'h00, FT, 1, 2, 0, 8'h00, 0);
        add("and0_hold",  0, 0, 0, 8'h00, FT, 1, 2, 0, 8'h00, 0);

        // AND r1,r2 on the extended ALU: executes with alu_op 2
        add("and1_rst",   1, 1, 1, 8'h36, Z,  0, 0, 0, 8'h00, 0);
        add("and1_idle",  0, 1, 1, 8'h36, Z,  0, 0, 0, 8'h00, 0);
        add("and1_fetch", 0, 1, 1, 8'h36, FP, 0, 0, 0, 8'h00, 0);
        add("and1_dec",   0, 1, 0, 8'h00, Z,  1, 2, 0, 8'h00, 0);
        add("and1_exec",  0, 1, 0, 8'h00, RW, 1, 2, 2, 8'h00, 0);
        add("and1_next",  0, 1, 0, 8'h00, FT, 1, 2, 0, 8'h00, 1);

        // HLT then mem_ready toggling, then reset leaves HALT
        add("hlt_rst",    1, 0, 1, 8'hF0, Z,  0, 0, 0, 8'h00, 0);
        add("hlt_idle",   0, 0, 1, 8'hF0, Z,  0, 0, 0, 8'h00, 0);
        add("hlt_fetch",  0, 0, 1, 8'hF0, FP, 0, 0, 0, 8'h00, 0);
        add("hlt_dec",    0, 0, 0, 8'h00, Z,  0, 0, 0, 8'h00, 0);
        add("hlt_h1",     0, 0, 1, 8'h16, HL, 0, 0, 0, 8'h00, 1);
        add("hlt_h2",     0, 0, 0, 8'h16, HL, 0, 0, 0, 8'h00, 1);
        add("hlt_h3",     0, 0, 1, 8'h16, HL, 0, 0, 0, 8'h00, 1);
        add("hlt_h4",     0, 0, 1, 8'h98, HL, 0, 0, 0, 8'h00, 1);
        add("hlt_reset",  1, 0, 1, 8'h00, Z,  0, 0, 0, 8'h00, 0);
        add("hlt_idle2",  0, 0, 0, 8'h00, Z,  0, 0, 0, 8'h00, 0);

        // Reset in the middle of a LOAD memory wait (ready in DECODE ignored)
        add("ab_rst",     1, 0, 1, 8'h98, Z,  0, 0, 0, 8'h00, 0);
        add("ab_idle",    0, 0, 1, 8'h98, Z,  0, 0, 0, 8'h00, 0);
        add("ab_fetch",   0, 0, 1, 8'h98, FP, 0, 0, 0, 8'h00, 0);
        add("ab_dec",     0, 0, 1, 8'h40, Z,  2, 0, 0, 8'h00, 0);
        add("ab_imm",     0, 0, 1, 8'h40, FP, 2, 0, 0, 8'h00, 0);
        add("ab_mem",     0, 0, 0, 8'h55, MR, 2, 0, 0, 8'h40, 0);
        add("ab_reset",   1, 0, 1, 8'h55, Z,  0, 0, 0, 8'h00, 0);
        add("ab_idle2",   0, 0, 1, 8'h00, Z,  0, 0, 0, 8'h00, 0);
        add("ab_fetch2",  0, 0, 1, 8'h00, FP, 0, 0, 0, 8'h00, 0);

        // Five NOPs into a 2-bit counter: saturates at 3
        add("sat_rst",    1, 1, 1, 8'h00, Z,  0, 0, 0, 8'h00, 0);
        add("sat_idle",   0, 1, 1, 8'h00, Z,  0, 0, 0, 8'h00, 0);
        for (int n = 0; n < 5; n++) begin
            add($sformatf("sat_f%0d", n), 0, 1, 1, 8'h00, FP, 0, 0, 0, 8'h00, 16'((n > 3) ? 3 : n));
            add($sformatf("sat_d%0d", n), 0, 1, 1, 8'h00, Z,  0, 0, 0, 8'h00, 16'((n > 3) ? 3 : n));
        end
        add("sat_end",    0, 1, 1, 8'h00, FP, 0, 0, 0, 8'h00, 3);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            mem_ready = vecs[i].rdy;
            mem_rdata = vecs[i].rdata;
            #1;
            check(vecs[i].name, vecs[i].sel_b ? obs_b() : obs_a(), vecs[i].exp);
        end

        // Bounded wait: first instruction fetch appears one cycle after reset release
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        cycles = 0;
        #1;
        while (!b_fetch && cycles < 10) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check("first_fetch_latency", 40'(cycles), 40'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
